oam_dma_ctrl: RTL and testbench
===============================

OAM_DMA_CTRL -- requirements
Module: oam_dma_ctrl

Interface
REQ-001 clk  input  1  system clock; all state changes on rising edge.
REQ-002 rst_n  input  1  reset, synchronous, active-low.
REQ-003 cpu_addr  input  16  CPU bus address, current cycle.
REQ-004 cpu_dout  input  8  CPU write data.
REQ-005 cpu_we  input  1  CPU write strobe, 1 = write cycle.
REQ-006 bus_din  input  8  read data returned from the shared bus, valid in the same cycle as bus_addr.
REQ-007 bus_addr  output  16  shared bus address (muxed CPU/DMA).
REQ-008 bus_dout  output  8  shared bus write data (muxed).
REQ-009 bus_we  output  1  shared bus write strobe (muxed).
REQ-010 rdy  output  1  CPU run enable, registered; 0 = CPU stalled.
REQ-011 dma_active  output  1  registered; 1 while the DMA owns the bus.

Function
REQ-012 The block SHALL keep a parity flop par, toggling every clk; par=0 marks a get cycle and par=1 marks a put cycle.
REQ-013 The block SHALL define the following states: IDLE, HALT, ALIGN, READ, WRITE.
REQ-014 Trigger: in IDLE, a cycle with cpu_we=1 and cpu_addr=16'h4014 SHALL latch page<=cpu_dout and idx<=0, and move to HALT at the next edge.
REQ-015 A write to any other address SHALL NOT trigger. While not in IDLE, writes to 16'h4014 SHALL be ignored.
REQ-016 HALT SHALL last one cycle. On exit, if par in the next cycle is 0, the block SHALL go to READ; otherwise it SHALL go to ALIGN.
REQ-017 ALIGN SHALL last one cycle, then go to READ. Every READ therefore occurs on a par=0 cycle.
REQ-018 READ SHALL drive bus_addr={page,idx}, bus_we=0 and latch data<=bus_din at the edge; the next state SHALL be WRITE.
REQ-019 WRITE SHALL drive bus_addr=16'h2004, bus_dout=data, bus_we=1.
REQ-020 At the end of WRITE, if idx=8'hFF the block SHALL go to IDLE. Otherwise it SHALL set idx<=idx+1 and go to READ.
REQ-021 idx is 8 bits and SHALL NOT carry into page.
REQ-022 Total stall SHALL be 513 cycles when the trigger write occurs with par=0, and 514 cycles when it occurs with par=1: 1 HALT + 0/1 ALIGN + 256 READ/WRITE pairs.
REQ-023 HALT and ALIGN SHALL be dummy cycles: bus_addr=cpu_addr, bus_dout=cpu_dout, bus_we=0.
REQ-024 In IDLE, bus_addr, bus_dout and bus_we SHALL equal cpu_addr, cpu_dout and cpu_we (combinational pass-through).
REQ-025 rdy SHALL be 1 exactly when the state is IDLE. dma_active SHALL be the inverse of rdy. rdy SHALL drop in the first cycle after the trigger write and rise in the first cycle after the final WRITE.

Reset
REQ-026 When rst_n=0 at an edge, the block SHALL set state=IDLE, par=0, idx=0, page=0 and data=0. After that edge rdy=1, dma_active=0, and the bus SHALL pass the CPU through.
REQ-027 Reset mid-transfer SHALL abort immediately, with no further DMA bus cycles. A following trigger SHALL start a full 256-byte transfer.
REQ-028 After reset, par SHALL be 0 in the first cycle with rst_n=1.

Verification
REQ-029 Even start: write 8'h02 to 4014 on a par=0 cycle -> rdy low for 513 cycles; first READ addr 16'h0200; 256 writes to 16'h2004; last READ addr 16'h02FF.
REQ-030 Odd start: same trigger on a par=1 cycle -> exactly one ALIGN cycle; rdy low for 514 cycles; every READ on par=0.
REQ-031 Data path: bus model returns bus_din=low byte of addr XOR 8'h5A -> WRITE n carries n^8'h5A for n=0..255, in order.
REQ-032 Spurious triggers: write to 16'h4015 -> no stall; write to 4014 during DMA -> ignored, page unchanged, length unchanged.
REQ-033 Reset mid-DMA: rst_n=0 for one cycle at idx=8'h40 -> next cycle rdy=1 and bus_we follows cpu_we; a new trigger with page 8'h03 -> 256 clean transfers starting at 16'h0300.
REQ-034 Back-to-back: second trigger issued in the first IDLE cycle after completion -> new HALT in the next cycle; no lost or duplicate write.

Source files
------------

// File: rtl/oam_dma_ctrl.sv
// OAM DMA controller.
// A CPU write of a page number to 16'h4014 stalls the CPU and copies the
// 256 bytes at {page, 8'h00}..{page, 8'hFF} into the OAM data port at
// 16'h2004, one byte per READ/WRITE pair. READs are aligned to get cycles
// (par=0), so an odd-cycle trigger costs one extra ALIGN cycle.
//
// Handshake: rdy is the CPU run enable. While rdy=1 the CPU owns the bus
// and every bus output is a combinational copy of the CPU request. While
// rdy=0 (dma_active=1) the CPU must hold off and the DMA drives the bus.
// Both flags are registered from the next state, so they change exactly on
// the edge where the state leaves or re-enters IDLE.
module oam_dma_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_dout,
    input  logic        cpu_we,
    input  logic [7:0]  bus_din,
    output logic [15:0] bus_addr,
    output logic [7:0]  bus_dout,
    output logic        bus_we,
    output logic        rdy,
    output logic        dma_active
);

    localparam logic [15:0] TRIGGER_ADDR = 16'h4014;
    localparam logic [15:0] OAM_DATA_ADDR = 16'h2004;
    localparam logic [7:0]  LAST_IDX = 8'hFF;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HALT  = 3'd1,
        ALIGN = 3'd2,
        READ  = 3'd3,
        WRITE = 3'd4
    } state_t;

    state_t     state;
    state_t     state_next;
    logic       par;       // 0 = get cycle, 1 = put cycle
    logic [7:0] page;      // source page, high byte of the read address
    logic [7:0] idx;       // byte index within the page; wraps, never carries
    logic [7:0] data;      // byte captured in READ, written out in WRITE
    logic       trigger;

    assign trigger = cpu_we && (cpu_addr == TRIGGER_ADDR);

    // Next-state logic. Triggers are only honoured in IDLE, so a write to
    // 4014 during a transfer has no effect on page or length.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (trigger) begin
                    state_next = HALT;
                end
            end
            HALT: begin
                // par flips at the edge, so par=1 now means a get cycle next.
                if (par) begin
                    state_next = READ;
                end else begin
                    state_next = ALIGN;
                end
            end
            ALIGN: begin
                state_next = READ;
            end
            READ: begin
                state_next = WRITE;
            end
            WRITE: begin
                if (idx == LAST_IDX) begin
                    state_next = IDLE;
                end else begin
                    state_next = READ;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register plus the run/ownership flags derived from next state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            rdy        <= 1'b1;
            dma_active <= 1'b0;
        end else begin
            state      <= state_next;
            rdy        <= (state_next == IDLE);
            dma_active <= (state_next != IDLE);
        end
    end

    // Free-running get/put parity; reset leaves par=0 in the first live cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            par <= 1'b0;
        end else begin
            par <= ~par;
        end
    end

    // Transfer datapath: latch the page on trigger, capture in READ,
    // advance the index after each WRITE except the last.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            page <= 8'h00;
            idx  <= 8'h00;
            data <= 8'h00;
        end else begin
            if (state == IDLE && trigger) begin
                page <= cpu_dout;
                idx  <= 8'h00;
            end
            if (state == READ) begin
                data <= bus_din;
            end
            if (state == WRITE && idx != LAST_IDX) begin
                idx <= idx + 8'd1;
            end
        end
    end

    // Bus multiplexer: CPU pass-through in IDLE, dummy (non-writing) CPU
    // cycles in HALT/ALIGN, DMA-driven cycles in READ/WRITE.
    always_comb begin
        bus_addr = cpu_addr;
        bus_dout = cpu_dout;
        bus_we   = 1'b0;
        case (state)
            IDLE: begin
                bus_we = cpu_we;
            end
            READ: begin
                bus_addr = {page, idx};
            end
            WRITE: begin
                bus_addr = OAM_DATA_ADDR;
                bus_dout = data;
                bus_we   = 1'b1;
            end
            default: begin
                bus_we = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Bench for oam_dma_ctrl: scoreboard of expected read addresses and
// written bytes, stall-length and dummy-cycle counting, spurious triggers,
// mid-transfer reset and a back-to-back trigger.
module tb_oam_dma_ctrl;

    localparam logic [15:0] IDLE_ADDR = 16'hBEEF;

    logic        clk;
    logic        rst_n;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_dout;
    logic        cpu_we;
    logic [7:0]  bus_din;
    logic [15:0] bus_addr;
    logic [7:0]  bus_dout;
    logic        bus_we;
    logic        rdy;
    logic        dma_active;

    oam_dma_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cpu_addr   (cpu_addr),
        .cpu_dout   (cpu_dout),
        .cpu_we     (cpu_we),
        .bus_din    (bus_din),
        .bus_addr   (bus_addr),
        .bus_dout   (bus_dout),
        .bus_we     (bus_we),
        .rdy        (rdy),
        .dma_active (dma_active)
    );

    // Clock and bus memory model.
    initial clk = 1'b0;
    always #5 clk = ~clk;
    assign bus_din = bus_addr[7:0] ^ 8'h5A;

    // Reference parity: cleared by a reset edge, toggles otherwise.
    logic tb_par;
    always @(posedge clk) tb_par <= rst_n ? ~tb_par : 1'b0;

    int checks = 0;
    int failures = 0;
    int dummy_cnt = 0;
    logic [15:0] last_rd_addr = 16'h0000;
    logic [15:0] exp_rd_q[$];
    logic [7:0]  exp_wr_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Monitor: classify every DMA-owned cycle and score it.
    always @(negedge clk) begin
        if (rst_n && dma_active) begin
            if (bus_we) begin
                check_eq("wr_addr", bus_addr, 16'h2004);
                if (exp_wr_q.size() == 0) check_eq("wr_extra", exp_wr_q.size(), 1);
                else check_eq("wr_data", bus_dout, exp_wr_q.pop_front());
            end else if (bus_addr == IDLE_ADDR) begin
                dummy_cnt++;
            end else begin
                last_rd_addr = bus_addr;
                check_eq("rd_par", tb_par, 0);
                if (exp_rd_q.size() == 0) check_eq("rd_extra", exp_rd_q.size(), 1);
                else check_eq("rd_addr", bus_addr, exp_rd_q.pop_front());
            end
        end
    end

    task automatic idle_inputs();
        cpu_we   = 1'b0;
        cpu_addr = IDLE_ADDR;
        cpu_dout = 8'h00;
    endtask

    // mode 0/1: wait for a trigger cycle with that parity; mode 2: trigger
    // in the current cycle (caller is at a negedge of an IDLE cycle).
    // inject: write 4014 again partway through the transfer.
    // full: wait for completion and score the length.
    task automatic run_dma(input logic [7:0] pg, input int mode, input bit inject, input bit full);
        int low;
        int exp_len;
        int exp_dummy;
        if (mode == 2) begin
            #1;
        end else begin
            for (int w = 0; w < 4; w++) begin
                @(posedge clk); #1;
                if (tb_par == mode[0]) break;
            end
        end
        exp_len   = tb_par ? 514 : 513;
        exp_dummy = tb_par ? 2 : 1;
        for (int i = 0; i < 256; i++) begin
            exp_rd_q.push_back({pg, i[7:0]});
            exp_wr_q.push_back(i[7:0] ^ 8'h5A);
        end
        dummy_cnt = 0;
        cpu_we   = 1'b1;
        cpu_addr = 16'h4014;
        cpu_dout = pg;
        @(posedge clk); #1;
        idle_inputs();
        if (!full) return;
        low = 0;
        for (int c = 0; c < 700; c++) begin
            @(negedge clk);
            if (rdy) break;
            low++;
            check_eq("dma_active", dma_active, 1);
            if (inject && low == 40) begin
                #1; cpu_we = 1'b1; cpu_addr = 16'h4014; cpu_dout = 8'h77;
            end else if (inject && low == 41) begin
                #1; idle_inputs();
            end
        end
        check_eq("stall_len", low, exp_len);
        check_eq("dummy_cycles", dummy_cnt, exp_dummy);
        check_eq("rd_left", exp_rd_q.size(), 0);
        check_eq("wr_left", exp_wr_q.size(), 0);
        check_eq("done_inactive", dma_active, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state and CPU pass-through.
        @(negedge clk);
        check_eq("rst_rdy", rdy, 1);
        check_eq("rst_active", dma_active, 0);
        #1; cpu_addr = 16'h1234; cpu_dout = 8'hAB; cpu_we = 1'b1;
        @(negedge clk);
        check_eq("pass_addr", bus_addr, 16'h1234);
        check_eq("pass_dout", bus_dout, 8'hAB);
        check_eq("pass_we", bus_we, 1);

        // Spurious trigger at the neighbouring address.
        #1; cpu_addr = 16'h4015; cpu_dout = 8'h02; cpu_we = 1'b1;
        @(posedge clk); #1; idle_inputs();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq("no_trig_rdy", rdy, 1);
        end

        // Even and odd starts; odd one also gets an ignored retrigger.
        run_dma(8'h02, 0, 1'b0, 1'b1);
        check_eq("even_last_rd", last_rd_addr, 16'h02FF);
        run_dma(8'h05, 1, 1'b1, 1'b1);
        check_eq("odd_last_rd", last_rd_addr, 16'h05FF);

        // Back-to-back: retrigger in the first IDLE cycle after completion.
        run_dma(8'h07, 2, 1'b0, 1'b1);

        // Reset in the middle of a transfer.
        run_dma(8'h01, 0, 1'b0, 1'b0);
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (last_rd_addr == 16'h0140) break;
        end
        check_eq("mid_reached", last_rd_addr, 16'h0140);
        #1; rst_n = 1'b0; cpu_we = 1'b1; cpu_addr = 16'h1111; cpu_dout = 8'h22;
        exp_rd_q.delete();
        exp_wr_q.delete();
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        check_eq("abort_rdy", rdy, 1);
        check_eq("abort_active", dma_active, 0);
        check_eq("abort_we", bus_we, 1);
        check_eq("abort_addr", bus_addr, 16'h1111);
        // First live cycle after reset has par=0, so this must take 513.
        run_dma(8'h03, 2, 1'b0, 1'b1);
        check_eq("post_rst_last_rd", last_rd_addr, 16'h03FF);

        repeat (3) @(negedge clk);
        check_eq("final_rdy", rdy, 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
